wavepool_instr_issue: RTL and testbench
=======================================

// Module: wavepool_instr_issue
// PURPOSE
//  Wavepool-side transmitter of the wavepool->decode instruction interface. Holds one fetched instruction
//  per wavefront slot, plus per-wavefront VGPR/SGPR/LDS base tables written at launch. Picks one ready
//  slot per cycle round-robin and drives registered wave_instr_* into the wavepool/decode flop stage.
//  The interface has no ready signal, so valid is a one-cycle pulse per issued instruction.
// PARAMETERS
//  NUM_WF   40  wavefront slots; wfid values >= NUM_WF are ignored on all inputs
// PORTS
//  clk               in   1   single clock, rising edge
//  rst               in   1   asynchronous, active-low reset (asserted when 0)
//  fetch_wr_en       in   1   write one instruction into a slot
//  fetch_wr_wfid     in   6   target slot
//  fetch_wr_pc       in   32  instruction PC
//  fetch_wr_instr    in   32  instruction word
//  launch_en         in   1   wavefront launch: load base tables, clear slot
//  launch_wfid       in   6   launched slot
//  launch_vgpr_base  in   10 / launch_sgpr_base in 9 / launch_lds_base in 16   per-wf bases
//  issue_stall       in   1   1 = no selection this cycle (decode/issue backpressure)
//  slot_empty        out  NUM_WF  bit i = 1 when slot i can accept a fetch write
//  fetch_overflow    out  1   sticky: a write hit an occupied, not-issuing slot
//  wave_instr_valid  out  1 / wave_instr_pc out 32 / wave_instr out 32 / wave_wfid out 6
//  wave_vgpr_base    out  10 / wave_sgpr_base out 9 / wave_lds_base out 16
// BEHAVIOUR
//  - Reset: every slot invalid (slot_empty all 1s). Base tables, wave_* outputs, fetch_overflow and the
//    RR pointer (= NUM_WF-1) all 0/reset. Reset mid-operation discards held instructions, no issue.
//  - Select (cycle N, combinational): when !issue_stall, grant = first valid slot after rr_ptr, with wrap.
//    At edge N: outputs load the slot's pc/instr/wfid/bases, valid=1, slot cleared, rr_ptr=grant.
//    The issue is visible at N+1 (latency 1 from slot-valid to wave_instr_valid).
//  - No grant (stall or no valid slot): wave_instr_valid=0 next cycle. Data outputs hold their last values.
//  - Fetch write to an empty slot sets it valid at the edge. It can be selected the following cycle.
//  - Fetch write to the slot being issued this cycle: issue takes the old contents and the new write lands.
//    The slot stays valid, allowing back-to-back issue from one wavefront.
//  - Fetch write to an occupied, non-issuing slot: dropped, fetch_overflow set until reset.
//  - Launch: writes bases[launch_wfid] and clears the slot. Same-cycle fetch to the same wfid: launch is
//    applied first, then the fetch write, so the slot holds the new instruction.
//    Same-cycle launch and issue of that wfid: the issue uses the OLD bases.
//  - Single valid slot equal to rr_ptr: still granted after a full wrap.
// CONFIGURATION
//  ISSUE_PERF_CNT_EN defined: adds outputs perf_issue_cnt[31:0] and perf_stall_cnt[31:0].
//    perf_issue_cnt = number of issued instructions. perf_stall_cnt = cycles with issue_stall=1 while any
//    slot was valid. Both wrap at 2^32 and reset to 0.
//  ISSUE_PERF_CNT_EN undefined: counters and ports are absent. Functional behaviour is identical.
// STRUCTURE
//  - Shared package/defines: WFID_W=6, VGPR_BASE_W=10, SGPR_BASE_W=9, LDS_BASE_W=16, PC_W=32, INSTR_W=32.
//  - Sub-module rr_arbiter #(N): inputs req[N-1:0] and ptr; outputs grant_onehot, grant_idx, grant_vld.
//    It is purely combinational.
//  - Top level holds slot storage, base tables, output register, the sticky flag and the optional counters.
// TESTING
//  - Reset: rst=0 with fetch writes active -> wave_instr_valid=0, slot_empty=all 1s, overflow=0.
//    After release, the first write still takes 1 cycle before it can issue.
//  - Launch wf 3 (vgpr 0x040, sgpr 0x020, lds 0x0100), then fetch wf3 pc=0x100 instr=0xBF810000.
//    Expect one valid pulse with wfid=3 and those bases; slot_empty[3] returns to 1.
//  - Slots 2, 5, 39 valid with rr_ptr=5 -> issue order 39, 2, 5 on consecutive cycles.
//  - issue_stall=1 for 4 cycles with slot 7 valid -> no valid pulses; wf7 issues 1 cycle after release.
//  - Write slot 9 while it is issuing -> the old and new instructions issue on consecutive cycles.
//    Write slot 9 while it is occupied and stalled -> write dropped, fetch_overflow=1.
//  - Same-cycle launch + fetch on wf 12 -> the slot holds the new instruction. With ISSUE_PERF_CNT_EN,
//    perf_issue_cnt equals the number of valid pulses seen.

Source files
------------

// File: rtl/wavepool_instr_issue_pkg.sv
// Shared widths and record types for the wavepool -> decode instruction issue path.
package wavepool_instr_issue_pkg;

   localparam int unsigned WfidW     = 6;
   localparam int unsigned VgprBaseW = 10;
   localparam int unsigned SgprBaseW = 9;
   localparam int unsigned LdsBaseW  = 16;
   localparam int unsigned PcW       = 32;
   localparam int unsigned InstrW    = 32;

   typedef struct packed {
      logic [VgprBaseW-1:0] vgpr;
      logic [SgprBaseW-1:0] sgpr;
      logic [LdsBaseW-1:0]  lds;
   } wf_base_t;

   typedef struct packed {
      logic [PcW-1:0]    pc;
      logic [InstrW-1:0] instr;
      logic [WfidW-1:0]  wfid;
      wf_base_t          base;
   } issue_out_t;

   // Out-of-range wavefront ids are silently ignored on every input.
   function automatic logic wfid_ok(input logic [WfidW-1:0] wfid, input int unsigned num_wf);
      return 32'(wfid) < num_wf;
   endfunction

endpackage

// File: rtl/wavepool_instr_issue_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after ptr_i, with wrap,
// so a lone requester equal to ptr_i is still granted.
module wavepool_instr_issue_rr_arbiter #(
   parameter int unsigned N    = 40,
   parameter int unsigned IdxW = $clog2(N)
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    grant_onehot_o,
   output logic [IdxW-1:0] grant_idx_o,
   output logic            grant_vld_o
);

   int unsigned pos;

   always_comb begin
      grant_onehot_o = '0;
      grant_idx_o    = '0;
      grant_vld_o    = 1'b0;
      pos            = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         pos = 32'(ptr_i) + k;
         if (pos >= N) begin
            pos = pos - N;
         end
         if (!grant_vld_o && req_i[IdxW'(pos)]) begin
            grant_vld_o                 = 1'b1;
            grant_idx_o                 = IdxW'(pos);
            grant_onehot_o[IdxW'(pos)]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wavepool_instr_issue.sv
// Wavepool -> decode instruction issue: per-wavefront instruction slots, launch-time base tables
// and a round-robin registered issue stage. Optional counters enabled by ISSUE_PERF_CNT_EN.
module wavepool_instr_issue
   import wavepool_instr_issue_pkg::*;
#(
   parameter int unsigned NumWf = 40
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 fetch_wr_en_i,
   input  logic [WfidW-1:0]     fetch_wr_wfid_i,
   input  logic [PcW-1:0]       fetch_wr_pc_i,
   input  logic [InstrW-1:0]    fetch_wr_instr_i,
   input  logic                 launch_en_i,
   input  logic [WfidW-1:0]     launch_wfid_i,
   input  logic [VgprBaseW-1:0] launch_vgpr_base_i,
   input  logic [SgprBaseW-1:0] launch_sgpr_base_i,
   input  logic [LdsBaseW-1:0]  launch_lds_base_i,
   input  logic                 issue_stall_i,
   output logic [NumWf-1:0]     slot_empty_o,
   output logic                 fetch_overflow_o,
`ifdef ISSUE_PERF_CNT_EN
   output logic [31:0]          perf_issue_cnt_o,
   output logic [31:0]          perf_stall_cnt_o,
`endif
   output logic                 wave_instr_valid_o,
   output logic [PcW-1:0]       wave_instr_pc_o,
   output logic [InstrW-1:0]    wave_instr_o,
   output logic [WfidW-1:0]     wave_wfid_o,
   output logic [VgprBaseW-1:0] wave_vgpr_base_o,
   output logic [SgprBaseW-1:0] wave_sgpr_base_o,
   output logic [LdsBaseW-1:0]  wave_lds_base_o
);

   logic [NumWf-1:0]  slot_valid_q, slot_valid_d;
   logic [PcW-1:0]    slot_pc_q    [NumWf];
   logic [InstrW-1:0] slot_instr_q [NumWf];
   wf_base_t          base_q       [NumWf];
   logic [WfidW-1:0]  rr_ptr_q, rr_ptr_d;
   logic              valid_q, valid_d;
   issue_out_t        out_q, out_d;
   logic              overflow_q, overflow_d;

   logic [NumWf-1:0]  grant_onehot;
   logic [WfidW-1:0]  grant_idx;
   logic              grant_vld;
   logic              issue;
   logic              fetch_hit;
   logic              launch_hit;
   logic              fetch_accept;
   logic [NumWf-1:0]  slot_after_clr;

   wavepool_instr_issue_rr_arbiter #(
      .N    (NumWf),
      .IdxW (WfidW)
   ) u_arb (
      .req_i          (slot_valid_q),
      .ptr_i          (rr_ptr_q),
      .grant_onehot_o (grant_onehot),
      .grant_idx_o    (grant_idx),
      .grant_vld_o    (grant_vld)
   );

   assign issue      = grant_vld & ~issue_stall_i;
   assign fetch_hit  = fetch_wr_en_i & wfid_ok(fetch_wr_wfid_i, NumWf);
   assign launch_hit = launch_en_i & wfid_ok(launch_wfid_i, NumWf);

   always_comb begin
      // Issue and launch both free their slot before the fetch write is judged, so a write to
      // the issuing or launching slot lands instead of overflowing.
      slot_after_clr = slot_valid_q;
      if (issue) begin
         slot_after_clr = slot_after_clr & ~grant_onehot;
      end
      for (int unsigned i = 0; i < NumWf; i++) begin
         if (launch_hit && (launch_wfid_i == WfidW'(i))) begin
            slot_after_clr[i] = 1'b0;
         end
      end

      fetch_accept = fetch_hit && !slot_after_clr[fetch_wr_wfid_i];
      slot_valid_d = slot_after_clr;
      if (fetch_accept) begin
         slot_valid_d[fetch_wr_wfid_i] = 1'b1;
      end
      overflow_d = overflow_q | (fetch_hit & ~fetch_accept);

      valid_d  = issue;
      rr_ptr_d = rr_ptr_q;
      out_d    = out_q;
      if (issue) begin
         rr_ptr_d    = grant_idx;
         out_d.pc    = slot_pc_q[grant_idx];
         out_d.instr = slot_instr_q[grant_idx];
         out_d.wfid  = grant_idx;
         out_d.base  = base_q[grant_idx];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_valid_q <= '0;
         rr_ptr_q     <= WfidW'(NumWf - 1);
         valid_q      <= 1'b0;
         out_q        <= '0;
         overflow_q   <= 1'b0;
      end else begin
         slot_valid_q <= slot_valid_d;
         rr_ptr_q     <= rr_ptr_d;
         valid_q      <= valid_d;
         out_q        <= out_d;
         overflow_q   <= overflow_d;
      end
   end

   // Issue reads base_q combinationally, so a same-cycle launch is only seen by later issues.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NumWf; i++) begin
            base_q[i] <= '0;
         end
      end else if (launch_hit) begin
         base_q[launch_wfid_i] <= '{vgpr: launch_vgpr_base_i,
                                    sgpr: launch_sgpr_base_i,
                                    lds:  launch_lds_base_i};
      end
   end

   // Payload storage needs no reset: slot_valid_q qualifies every read.
   always_ff @(posedge clk_i) begin
      if (fetch_accept) begin
         slot_pc_q[fetch_wr_wfid_i]    <= fetch_wr_pc_i;
         slot_instr_q[fetch_wr_wfid_i] <= fetch_wr_instr_i;
      end
   end

`ifdef ISSUE_PERF_CNT_EN
   logic [31:0] perf_issue_q, perf_issue_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   always_comb begin
      perf_issue_d = perf_issue_q + 32'(issue);
      perf_stall_d = perf_stall_q + 32'(issue_stall_i & (|slot_valid_q));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_issue_q <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_issue_q <= perf_issue_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_issue_cnt_o = perf_issue_q;
   assign perf_stall_cnt_o = perf_stall_q;
`endif

   assign slot_empty_o       = ~slot_valid_q;
   assign fetch_overflow_o   = overflow_q;
   assign wave_instr_valid_o = valid_q;
   assign wave_instr_pc_o    = out_q.pc;
   assign wave_instr_o       = out_q.instr;
   assign wave_wfid_o        = out_q.wfid;
   assign wave_vgpr_base_o   = out_q.base.vgpr;
   assign wave_sgpr_base_o   = out_q.base.sgpr;
   assign wave_lds_base_o    = out_q.base.lds;

endmodule

// File: tb/tb_wavepool_instr_issue.sv
// Bench for wavepool_instr_issue: directed vector table plus randomized traffic against a
// slot-level reference model. Perf counters are checked when ISSUE_PERF_CNT_EN is defined.
module tb_wavepool_instr_issue;

   localparam int NWF = 40;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           fetch_wr_en;
   logic [5:0]     fetch_wr_wfid;
   logic [31:0]    fetch_wr_pc;
   logic [31:0]    fetch_wr_instr;
   logic           launch_en;
   logic [5:0]     launch_wfid;
   logic [9:0]     launch_vgpr_base;
   logic [8:0]     launch_sgpr_base;
   logic [15:0]    launch_lds_base;
   logic           issue_stall;
   logic [NWF-1:0] slot_empty;
   logic           fetch_overflow;
   logic           wave_instr_valid;
   logic [31:0]    wave_instr_pc;
   logic [31:0]    wave_instr;
   logic [5:0]     wave_wfid;
   logic [9:0]     wave_vgpr_base;
   logic [8:0]     wave_sgpr_base;
   logic [15:0]    wave_lds_base;
`ifdef ISSUE_PERF_CNT_EN
   logic [31:0]    perf_issue_cnt;
   logic [31:0]    perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   wavepool_instr_issue #(
      .NumWf (NWF)
   ) dut (
      .clk_i              (clk),
      .rst_ni             (rst_n),
      .fetch_wr_en_i      (fetch_wr_en),
      .fetch_wr_wfid_i    (fetch_wr_wfid),
      .fetch_wr_pc_i      (fetch_wr_pc),
      .fetch_wr_instr_i   (fetch_wr_instr),
      .launch_en_i        (launch_en),
      .launch_wfid_i      (launch_wfid),
      .launch_vgpr_base_i (launch_vgpr_base),
      .launch_sgpr_base_i (launch_sgpr_base),
      .launch_lds_base_i  (launch_lds_base),
      .issue_stall_i      (issue_stall),
      .slot_empty_o       (slot_empty),
      .fetch_overflow_o   (fetch_overflow),
`ifdef ISSUE_PERF_CNT_EN
      .perf_issue_cnt_o   (perf_issue_cnt),
      .perf_stall_cnt_o   (perf_stall_cnt),
`endif
      .wave_instr_valid_o (wave_instr_valid),
      .wave_instr_pc_o    (wave_instr_pc),
      .wave_instr_o       (wave_instr),
      .wave_wfid_o        (wave_wfid),
      .wave_vgpr_base_o   (wave_vgpr_base),
      .wave_sgpr_base_o   (wave_sgpr_base),
      .wave_lds_base_o    (wave_lds_base)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: slots as plain arrays, grant by scanning from the last grant.
   bit          mv  [NWF];
   logic [31:0] mpc [NWF];
   logic [31:0] min [NWF];
   logic [9:0]  mbv [NWF];
   logic [8:0]  mbs [NWF];
   logic [15:0] mbl [NWF];
   int          mptr;
   logic        e_valid, e_ovf;
   logic [31:0] e_pc, e_in;
   logic [5:0]  e_wfid;
   logic [9:0]  e_bv;
   logic [8:0]  e_bs;
   logic [15:0] e_bl;
   int unsigned m_iss, m_stl, pulses;

   typedef struct packed {
      logic        le;
      logic [5:0]  lw;
      logic [9:0]  lv;
      logic [8:0]  ls;
      logic [15:0] ll;
      logic        fe;
      logic [5:0]  fw;
      logic [31:0] fpc;
      logic [31:0] fin;
      logic        st;
      logic        ev;
      logic [5:0]  ewf;
      logic [31:0] epc;
      logic [31:0] ein;
      logic [9:0]  ebv;
      logic [8:0]  ebs;
      logic [15:0] ebl;
      logic        eovf;
   } vec_t;

   vec_t tbl[$];
   logic cur_ovf = 1'b0;

   function automatic vec_t rin(input logic le, input logic [5:0] lw, input logic [9:0] lv,
                                input logic [8:0] ls, input logic [15:0] ll, input logic fe,
                                input logic [5:0] fw, input logic [31:0] fpc,
                                input logic [31:0] fin, input logic st);
      vec_t v;
      v      = '0;
      v.le   = le;  v.lw = lw;  v.lv = lv;  v.ls = ls;  v.ll = ll;
      v.fe   = fe;  v.fw = fw;  v.fpc = fpc; v.fin = fin; v.st = st;
      v.eovf = cur_ovf;
      return v;
   endfunction

   function automatic vec_t idle(input logic st);
      return rin(0, 0, 0, 0, 0, 0, 0, 0, 0, st);
   endfunction

   function automatic vec_t rex(input vec_t vi, input logic [5:0] wf, input logic [31:0] pc,
                                input logic [31:0] in, input logic [9:0] bv,
                                input logic [8:0] bs, input logic [15:0] bl);
      vec_t v;
      v     = vi;
      v.ev  = 1'b1; v.ewf = wf;  v.epc = pc; v.ein = in;
      v.ebv = bv;   v.ebs = bs;  v.ebl = bl;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NWF; k++) begin
         mv[k] = 1'b0; mbv[k] = '0; mbs[k] = '0; mbl[k] = '0;
      end
      mptr = NWF - 1;
      e_valid = 1'b0; e_ovf = 1'b0; e_pc = '0; e_in = '0; e_wfid = '0;
      e_bv = '0; e_bs = '0; e_bl = '0;
      m_iss = 0; m_stl = 0; pulses = 0;
   endtask

   task automatic model_step();
      int g;
      bit any;
      g   = -1;
      any = 1'b0;
      for (int k = 0; k < NWF; k++) if (mv[k]) any = 1'b1;
      if (!issue_stall) begin
         for (int k = 1; k <= NWF; k++) begin
            int j;
            j = (mptr + k) % NWF;
            if (g < 0 && mv[j]) g = j;
         end
      end
      e_valid = (g >= 0);
      if (g >= 0) begin
         e_pc = mpc[g]; e_in = min[g]; e_wfid = 6'(g);
         e_bv = mbv[g]; e_bs = mbs[g]; e_bl = mbl[g];
         mptr = g; mv[g] = 1'b0; m_iss++;
      end
      if (issue_stall && any) m_stl++;
      if (launch_en && int'(launch_wfid) < NWF) begin
         mbv[launch_wfid] = launch_vgpr_base;
         mbs[launch_wfid] = launch_sgpr_base;
         mbl[launch_wfid] = launch_lds_base;
         mv[launch_wfid]  = 1'b0;
      end
      if (fetch_wr_en && int'(fetch_wr_wfid) < NWF) begin
         if (mv[fetch_wr_wfid]) begin
            e_ovf = 1'b1;
         end else begin
            mv[fetch_wr_wfid]  = 1'b1;
            mpc[fetch_wr_wfid] = fetch_wr_pc;
            min[fetch_wr_wfid] = fetch_wr_instr;
         end
      end
   endtask

   task automatic check_model();
      logic [NWF-1:0] emp;
      for (int k = 0; k < NWF; k++) emp[k] = !mv[k];
      chk("m_valid", 64'(wave_instr_valid), 64'(e_valid));
      chk("m_pc", 64'(wave_instr_pc), 64'(e_pc));
      chk("m_instr", 64'(wave_instr), 64'(e_in));
      chk("m_wfid", 64'(wave_wfid), 64'(e_wfid));
      chk("m_vgpr", 64'(wave_vgpr_base), 64'(e_bv));
      chk("m_sgpr", 64'(wave_sgpr_base), 64'(e_bs));
      chk("m_lds", 64'(wave_lds_base), 64'(e_bl));
      chk("m_slot_empty", 64'(slot_empty), 64'(emp));
      chk("m_overflow", 64'(fetch_overflow), 64'(e_ovf));
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check_model();
      if (wave_instr_valid === 1'b1) pulses++;
   endtask

   task automatic apply(input vec_t v);
      launch_en = v.le; launch_wfid = v.lw; launch_vgpr_base = v.lv;
      launch_sgpr_base = v.ls; launch_lds_base = v.ll;
      fetch_wr_en = v.fe; fetch_wr_wfid = v.fw; fetch_wr_pc = v.fpc; fetch_wr_instr = v.fin;
      issue_stall = v.st;
   endtask

   task automatic drive_random();
      fetch_wr_en      = ($urandom_range(0, 99) < 60);
      fetch_wr_wfid    = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 5))
                                                     : 6'($urandom_range(36, 41));
      fetch_wr_pc      = $urandom;
      fetch_wr_instr   = $urandom;
      launch_en        = ($urandom_range(0, 99) < 8);
      launch_wfid      = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 5))
                                                     : 6'($urandom_range(36, 41));
      launch_vgpr_base = 10'($urandom);
      launch_sgpr_base = 9'($urandom);
      launch_lds_base  = 16'($urandom);
      issue_stall      = ($urandom_range(0, 99) < 30);
   endtask

   initial begin
      // Directed table: inputs for one cycle, expected outputs just after that edge.
      tbl.push_back(rin(1, 3, 'h040, 'h020, 'h0100, 0, 0, 0, 0, 0));
      tbl.push_back(rin(0, 0, 0, 0, 0, 1, 3, 'h100, 'hBF810000, 0));
      tbl.push_back(rex(idle(0), 3, 'h100, 'hBF810000, 'h040, 'h020, 'h0100));
      tbl.push_back(idle(0));
      tbl.push_back(rin(0, 0, 0, 0, 0, 1, 5, 'h500, 'h55, 0));
      tbl.push_back(rex(rin(0, 0, 0, 0, 0, 1, 2, 'h200, 'h22, 0), 5, 'h500, 'h55, 0, 0, 0));
      tbl.push_back(rin(0, 0, 0, 0, 0, 1, 39, 'h3900, 'h39, 1));
      tbl.push_back(rin(0, 0, 0, 0, 0, 1, 5, 'h504, 'h56, 1));
      tbl.push_back(rex(idle(0), 39, 'h3900, 'h39, 0, 0, 0));
      tbl.push_back(rex(idle(0), 2, 'h200, 'h22, 0, 0, 0));
      tbl.push_back(rex(idle(0), 5, 'h504, 'h56, 0, 0, 0));
      tbl.push_back(idle(0));
      tbl.push_back(rin(0, 0, 0, 0, 0, 1, 7, 'h700, 'h77, 1));
      for (int k = 0; k < 4; k++) tbl.push_back(idle(1));
      tbl.push_back(rex(idle(0), 7, 'h700, 'h77, 0, 0, 0));
      tbl.push_back(idle(0));
      tbl.push_back(rin(0, 0, 0, 0, 0, 1, 12, 'hC00, 'hC0, 1));
      tbl.push_back(rin(1, 12, 'h0AA, 'h055, 'h1234, 1, 12, 'hC04, 'hC1, 1));
      tbl.push_back(rex(idle(0), 12, 'hC04, 'hC1, 'h0AA, 'h055, 'h1234));
      tbl.push_back(idle(0));
      tbl.push_back(rin(0, 0, 0, 0, 0, 1, 3, 'h104, 'h31, 1));
      tbl.push_back(rex(rin(1, 3, 'h3FF, 'h1FF, 'hFFFF, 0, 0, 0, 0, 0),
                        3, 'h104, 'h31, 'h040, 'h020, 'h0100));
      tbl.push_back(idle(0));
      tbl.push_back(rin(0, 0, 0, 0, 0, 1, 3, 'h108, 'h32, 0));
      tbl.push_back(rex(idle(0), 3, 'h108, 'h32, 'h3FF, 'h1FF, 'hFFFF));
      tbl.push_back(rin(1, 50, 'h111, 'h011, 'h1111, 1, 45, 'hDEAD, 'hBEEF, 0));
      tbl.push_back(idle(0));
      tbl.push_back(rin(0, 0, 0, 0, 0, 1, 9, 'h900, 'h90, 0));
      tbl.push_back(rex(rin(0, 0, 0, 0, 0, 1, 9, 'h904, 'h91, 0), 9, 'h900, 'h90, 0, 0, 0));
      tbl.push_back(rex(idle(0), 9, 'h904, 'h91, 0, 0, 0));
      tbl.push_back(idle(0));
      tbl.push_back(rin(0, 0, 0, 0, 0, 1, 9, 'h908, 'h92, 1));
      cur_ovf = 1'b1;
      tbl.push_back(rin(0, 0, 0, 0, 0, 1, 9, 'h90C, 'h93, 1));
      tbl.push_back(rex(idle(0), 9, 'h908, 'h92, 0, 0, 0));
      tbl.push_back(idle(0));

      // Reset held with fetch writes active.
      rst_n = 1'b0;
      apply(rin(0, 0, 0, 0, 0, 1, 0, 'h10, 'h20, 0));
      model_reset();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         fetch_wr_wfid = 6'(k + 1);
         chk("rst_valid", 64'(wave_instr_valid), 64'd0);
         chk("rst_empty", 64'(slot_empty), 64'({NWF{1'b1}}));
         chk("rst_overflow", 64'(fetch_overflow), 64'd0);
      end
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         apply(tbl[i]);
         step();
         chk($sformatf("tbl%0d_valid", i), 64'(wave_instr_valid), 64'(tbl[i].ev));
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d_wfid", i), 64'(wave_wfid), 64'(tbl[i].ewf));
            chk($sformatf("tbl%0d_pc", i), 64'(wave_instr_pc), 64'(tbl[i].epc));
            chk($sformatf("tbl%0d_instr", i), 64'(wave_instr), 64'(tbl[i].ein));
            chk($sformatf("tbl%0d_vgpr", i), 64'(wave_vgpr_base), 64'(tbl[i].ebv));
            chk($sformatf("tbl%0d_sgpr", i), 64'(wave_sgpr_base), 64'(tbl[i].ebs));
            chk($sformatf("tbl%0d_lds", i), 64'(wave_lds_base), 64'(tbl[i].ebl));
         end
         chk($sformatf("tbl%0d_overflow", i), 64'(fetch_overflow), 64'(tbl[i].eovf));
      end

      for (int n = 0; n < 3000; n++) begin
         drive_random();
         step();
      end

      // Reset mid-operation: held instructions are discarded.
      for (int n = 0; n < 20; n++) begin
         drive_random();
         issue_stall = 1'b1;
         step();
      end
      drive_random();
      #2;
      rst_n = 1'b0;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         drive_random();
         check_model();
      end
      rst_n = 1'b1;

      for (int n = 0; n < 500; n++) begin
         drive_random();
         step();
      end

`ifdef ISSUE_PERF_CNT_EN
      chk("perf_issue", 64'(perf_issue_cnt), 64'(m_iss));
      chk("perf_issue_pulses", 64'(perf_issue_cnt), 64'(pulses));
      chk("perf_stall", 64'(perf_stall_cnt), 64'(m_stl));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
